// File: rtl/ctl_seq.sv
// Control sequencer: accepts ops over valid/ready and drives the register bank's write and read ports.
// Optional retire counter output is enabled by defining CTL_RETIRE_CNT_EN.
module ctl_seq #(
  parameter int OP_W   = 8,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 6,
  parameter logic [OP_W-1:0] OP_NOP      = OP_W'(8'h00),
  parameter logic [OP_W-1:0] OP_LOAD_IMM = OP_W'(8'h01),
  parameter logic [OP_W-1:0] OP_MOV      = OP_W'(8'h02),
  parameter logic [OP_W-1:0] OP_CLR      = OP_W'(8'h03)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   ctl_op,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic [SEL_W-1:0]  reg_src,
  input  logic [DATA_W-1:0] data_in,
  output logic              regbank_we,
  output logic [SEL_W-1:0]  regbank_sel,
  output logic [DATA_W-1:0] regbank_valout,
  output logic              regbank_re,
  output logic [SEL_W-1:0]  regbank_rsel,
  input  logic [DATA_W-1:0] regbank_rdata,
  output logic              busy,
  output logic              op_err,
`ifdef CTL_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: an op is accepted at a rising edge where op_valid && op_ready;
  // operands are captured at that edge and ignored at every other edge.
  typedef enum logic [1:0] {IDLE, RD, RWAIT, WR} state_t;

  state_t              state, state_d;
  logic                we_d, re_d, err_d, accept;
  logic [SEL_W-1:0]    sel_d, rsel_d, dest_q, dest_d;
  logic [DATA_W-1:0]   val_d;

  assign op_ready  = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);
  assign accept    = op_valid && op_ready;
  assign state_dbg = state;

  always_comb begin
    state_d = state;
    we_d    = 1'b0;
    re_d    = 1'b0;
    err_d   = 1'b0;
    sel_d   = regbank_sel;
    rsel_d  = regbank_rsel;
    val_d   = regbank_valout;
    dest_d  = dest_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          case (ctl_op)
            OP_NOP: ;
            OP_LOAD_IMM: begin
              sel_d   = reg_sel;
              val_d   = data_in;
              we_d    = 1'b1;
              state_d = WR;
            end
            OP_CLR: begin
              sel_d   = reg_sel;
              val_d   = '0;
              we_d    = 1'b1;
              state_d = WR;
            end
            OP_MOV: begin
              rsel_d  = reg_src;
              dest_d  = reg_sel;
              re_d    = 1'b1;
              state_d = RD;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      RD:    state_d = RWAIT;
      // The bank presents read data one cycle after it samples the read strobe.
      RWAIT: begin
        val_d   = regbank_rdata;
        sel_d   = dest_q;
        we_d    = 1'b1;
        state_d = WR;
      end
      WR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      regbank_we     <= 1'b0;
      regbank_re     <= 1'b0;
      op_err         <= 1'b0;
      regbank_sel    <= '0;
      regbank_rsel   <= '0;
      regbank_valout <= '0;
      dest_q         <= '0;
    end else begin
      state          <= state_d;
      regbank_we     <= we_d;
      regbank_re     <= re_d;
      op_err         <= err_d;
      regbank_sel    <= sel_d;
      regbank_rsel   <= rsel_d;
      regbank_valout <= val_d;
      dest_q         <= dest_d;
    end
  end

`ifdef CTL_RETIRE_CNT_EN
  // Retires on the write-strobe deassert edge (WR->IDLE) and on NOP acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if ((state == WR) || (accept && (ctl_op == OP_NOP))) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctl_seq.sv
// Bench for ctl_seq: directed scenarios plus randomized ops checked by a write/read scoreboard
// against a register-file reference model.
module tb_ctl_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  ctl_op;
  logic [5:0]  reg_sel, reg_src;
  logic [63:0] data_in;
  logic        regbank_we, regbank_re, busy, op_err;
  logic [5:0]  regbank_sel, regbank_rsel;
  logic [63:0] regbank_valout, regbank_rdata;
  logic [1:0]  state_dbg;
`ifdef CTL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [69:0] exp_wr_q[$];
  logic [5:0]  exp_rd_q[$];
  int          pending_err = 0;
  logic [63:0] ref_rf[64];
  logic [63:0] bank[64];

  ctl_seq dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .ctl_op(ctl_op), .reg_sel(reg_sel), .reg_src(reg_src), .data_in(data_in),
    .regbank_we(regbank_we), .regbank_sel(regbank_sel), .regbank_valout(regbank_valout),
    .regbank_re(regbank_re), .regbank_rsel(regbank_rsel), .regbank_rdata(regbank_rdata),
    .busy(busy), .op_err(op_err),
`ifdef CTL_RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register bank: one-cycle read latency, not reset
  initial begin
    for (int i = 0; i < 64; i++) begin
      bank[i]   = '0;
      ref_rf[i] = '0;
    end
    regbank_rdata = '0;
  end

  always @(posedge clk) begin
    if (regbank_we) bank[regbank_sel] <= regbank_valout;
    if (regbank_re) regbank_rdata <= bank[regbank_rsel];
  end

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (regbank_we && regbank_re) chk("we_re_overlap", 70'(1), 70'(0));
      if (regbank_we) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", {regbank_sel, regbank_valout}, 70'(0));
        else chk("write", {regbank_sel, regbank_valout}, exp_wr_q.pop_front());
      end
      if (regbank_re) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", 70'(regbank_rsel), 70'(0));
        else chk("read_sel", 70'(regbank_rsel), 70'(exp_rd_q.pop_front()));
      end
      if (op_err) begin
        chk("op_err_expected", 70'(pending_err > 0), 70'(1));
        if (pending_err > 0) pending_err--;
      end
    end
  end

  // driver: waits for op_ready at a falling edge, presents the op across one rising edge
  task automatic issue_op(input logic [7:0] op, input logic [5:0] sel, input logic [5:0] src,
                          input logic [63:0] data);
    int guard = 0;
    @(negedge clk);
    while (!op_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (!op_ready) begin
      chk("ready_timeout", 70'(op_ready), 70'(1));
      return;
    end
    ctl_op = op; reg_sel = sel; reg_src = src; data_in = data; op_valid = 1'b1;
    case (op)
      8'h00: ;
      8'h01: begin exp_wr_q.push_back({sel, data}); ref_rf[sel] = data; end
      8'h03: begin exp_wr_q.push_back({sel, 64'd0}); ref_rf[sel] = '0; end
      8'h02: begin
        exp_rd_q.push_back(src);
        exp_wr_q.push_back({sel, ref_rf[src]});
        ref_rf[sel] = ref_rf[src];
      end
      default: pending_err++;
    endcase
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || pending_err != 0 || busy) && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    chk("drain", 70'(exp_wr_q.size() + exp_rd_q.size() + pending_err), 70'(0));
  endtask

  initial begin
    int mis;
    logic [7:0] op;
    rst_n = 1'b0; op_valid = 1'b0; ctl_op = '0; reg_sel = '0; reg_src = '0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {regbank_we, regbank_re, op_err, busy, op_ready, regbank_sel, regbank_rsel},
        70'(0));
    chk("rst_valout", 70'(regbank_valout), 70'(0));
    chk("rst_state", 70'(state_dbg), 70'(0));
    rst_n = 1'b1;
    #1 chk("ready_after_rst", 70'(op_ready), 70'(1));

    // LOAD_IMM r5
    issue_op(8'h01, 6'd5, 6'd0, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    chk("load_we", {regbank_we, op_ready, regbank_sel}, {1'b1, 1'b0, 6'd5});
    chk("load_val", 70'(regbank_valout), 70'(64'hDEAD_BEEF_0123_4567));
    @(negedge clk);
    chk("load_done", {regbank_we, op_ready}, {1'b0, 1'b1});
    chk("load_hold", 70'(regbank_valout), 70'(64'hDEAD_BEEF_0123_4567));

    // LOAD r3 then MOV r3 -> r9
    issue_op(8'h01, 6'd3, 6'd0, 64'h55);
    repeat (2) @(negedge clk);
    issue_op(8'h02, 6'd9, 6'd3, 64'h0);
    @(negedge clk);
    chk("mov_rd", {regbank_re, regbank_we, busy, regbank_rsel}, {1'b1, 1'b0, 1'b1, 6'd3});
    @(negedge clk);
    chk("mov_rwait", {regbank_re, regbank_we, busy}, {1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("mov_wr", {regbank_we, busy, regbank_sel}, {1'b1, 1'b1, 6'd9});
    chk("mov_val", 70'(regbank_valout), 70'(64'h55));
    @(negedge clk);
    chk("mov_idle", {regbank_we, busy}, {1'b0, 1'b0});

    // CLR r63
    issue_op(8'h03, 6'd63, 6'd0, 64'hFFFF);
    @(negedge clk);
    chk("clr_wr", {regbank_we, regbank_sel}, {1'b1, 6'd63});
    chk("clr_val", 70'(regbank_valout), 70'(0));

    // unknown opcode
    issue_op(8'hA7, 6'd1, 6'd2, 64'h1);
    @(negedge clk);
    chk("unk_pulse", {op_err, op_ready, regbank_we, regbank_re}, {1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("unk_end", 70'(op_err), 70'(0));

    // reset during MOV's RWAIT (src == dest, so the expected register contents are unaffected)
    issue_op(8'h02, 6'd9, 6'd9, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {regbank_we, regbank_re, op_err, busy, op_ready, regbank_sel, regbank_rsel},
        70'(0));
    chk("midrst_valout", 70'(regbank_valout), 70'(0));
    void'(exp_wr_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    issue_op(8'h01, 6'd9, 6'd0, 64'h1234_5678);
    @(negedge clk);
    chk("post_rst_load", {regbank_we, regbank_sel}, {1'b1, 6'd9});
    drain();

`ifdef CTL_RETIRE_CNT_EN
    apply_reset();
    issue_op(8'h00, 6'd0, 6'd0, 64'h0);
    issue_op(8'h01, 6'd4, 6'd0, 64'h77);
    issue_op(8'hFF, 6'd0, 6'd0, 64'h0);
    issue_op(8'h02, 6'd8, 6'd4, 64'h0);
    drain();
    chk("retire_cnt", 70'(retire_cnt), 70'(3));
    @(negedge clk);
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    issue_op(8'h00, 6'd0, 6'd0, 64'h0);
    @(negedge clk);
    chk("retire_wrap", 70'(retire_cnt), 70'(0));
`endif

    // randomized ops
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0 || r == 9) op = 8'h00;
      else if (r <= 3)      op = 8'h01;
      else if (r == 4)      op = 8'h03;
      else if (r <= 7)      op = 8'h02;
      else                  op = 8'($urandom_range(4, 255));
      issue_op(op, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    repeat (2) @(negedge clk);
    mis = 0;
    for (int i = 0; i < 64; i++) if (bank[i] !== ref_rf[i]) mis++;
    chk("bank_contents", 70'(mis), 70'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ctl_seq.md
Name: ctl_seq

Overview:
- Parametrised successor to the single-cycle control unit.
- Accepts control operations over a valid/ready handshake and sequences them through a small FSM.
- Drives the register bank's write port and a new synchronous read port, so it supports register-to-register moves and clears as well as immediate loads.
- Sits between the instruction decode front-end and the register bank.
- Write enable is a true one-cycle pulse, not a sticky level.

Parameters:
- OP_W, 8, width of the operation code.
- DATA_W, 64, register data width.
- SEL_W, 6, register select width (2^SEL_W registers).
- OP_NOP, 8'h00, no operation.
- OP_LOAD_IMM, 8'h01, write data_in to reg_sel.
- OP_MOV, 8'h02, copy register reg_src to reg_sel.
- OP_CLR, 8'h03, write zero to reg_sel.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  operation presented.
- op_ready  out  1  block can accept an operation.
- ctl_op  in  OP_W  operation code.
- reg_sel  in  SEL_W  destination register.
- reg_src  in  SEL_W  source register (OP_MOV only).
- data_in  in  DATA_W  immediate (OP_LOAD_IMM only).
- regbank_we  out  1  write strobe.
- regbank_sel  out  SEL_W  write register select.
- regbank_valout  out  DATA_W  write data.
- regbank_re  out  1  read strobe.
- regbank_rsel  out  SEL_W  read register select.
- regbank_rdata  in  DATA_W  read data; valid the cycle after regbank_re is sampled.
- busy  out  1  FSM not in IDLE.
- op_err  out  1  one-cycle pulse when an unknown opcode is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Registered outputs: every output except op_ready and busy is a flop.
- Reset values: state=IDLE. regbank_we, regbank_re and op_err are 0. regbank_sel, regbank_rsel and regbank_valout are 0.
- Combinational outputs: op_ready = (state==IDLE) && rst_n. busy = (state!=IDLE).
- Accept rule: an op is accepted at a rising edge where op_valid && op_ready. Operands are captured at that edge. Inputs are don't-care otherwise.
- FSM states: IDLE, RD, RWAIT, WR.
- OP_NOP (accept at edge k): state stays IDLE; no strobes; next accept possible at edge k+1.
- OP_LOAD_IMM (accept at edge k):
  - At k: regbank_sel<=reg_sel, regbank_valout<=data_in, regbank_we<=1, state<=WR.
  - At k+1: regbank_we<=0, state<=IDLE.
  - Result: exactly one we cycle; op_ready low during cycle k..k+1.
- OP_CLR: identical to OP_LOAD_IMM, but valout<=0.
- OP_MOV (accept at edge k):
  - At k: regbank_re<=1, regbank_rsel<=reg_src, dest latched, state<=RD.
  - At k+1: regbank_re<=0, state<=RWAIT.
  - At k+2: regbank_valout<=regbank_rdata, regbank_sel<=dest, regbank_we<=1, state<=WR.
  - At k+3: we<=0, state<=IDLE.
  - reg_src==reg_sel is legal and writes back the same value.
- Unknown opcode (accept at edge k): op_err<=1 for one cycle; state stays IDLE; no regbank strobes.
- Strobe independence: regbank_we and regbank_re are never high in the same cycle.
- Output hold: sel, rsel and valout hold their last value when strobes are low.
- Reset mid-operation: FSM returns to IDLE and all outputs take reset values immediately. The in-flight op is dropped; no write issues after rst_n rises. First accept is possible at the first rising edge with rst_n high.
- Back-to-back ops: a continuously asserted op_valid sustains one op per 2 cycles for LOAD_IMM/CLR, 4 for MOV, and 1 for NOP/unknown.

Optional Feature:
- Macro: CTL_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt [31:0], reset 0.
  - Increments by 1 on the edge a LOAD_IMM/CLR/MOV write strobe deasserts (WR->IDLE), and on NOP acceptance.
  - Unknown ops are not counted.
  - Wraps from 32'hFFFF_FFFF to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then LOAD_IMM reg_sel=5, data_in=64'hDEAD_BEEF_0123_4567 -> regbank_we high exactly 1 cycle with sel=5 and valout=that value; op_ready low that cycle, high after.
- LOAD_IMM r3=64'h55 then MOV reg_src=3 -> reg_sel=9, with a bench regfile of 1-cycle read latency -> re pulses 1 cycle with rsel=3; 2 cycles later we pulses with sel=9 and valout=64'h55; busy high 3 cycles.
- CLR reg_sel=63 -> we 1 cycle, sel=63, valout=0.
- ctl_op=8'hA7 -> op_err pulses 1 cycle; we and re stay 0; op_ready stays high.
- Assert rst_n low during MOV's RWAIT -> outputs at reset values immediately; no we after release; a subsequent LOAD_IMM completes normally.
- With CTL_RETIRE_CNT_EN: NOP, LOAD_IMM, 8'hFF, MOV -> retire_cnt ends at 3. Force the counter to 32'hFFFF_FFFF, then NOP -> retire_cnt=0.
